multi_channel_scoreboard: RTL and testbench
===========================================

Name: multi_channel_scoreboard

Overview:
Parametrised successor to the single-channel simple scoreboard. It tracks one tagged packet per channel, on every channel of the arbitrated FIFO array at once, and checks that each packet comes out of the shared data_out in FIFO order with its data unchanged. It sits beside arbitrated_fifos in the formal/sim top and observes push, gnt (pop), flat_data_in and data_out. It produces per-channel verdicts and one aggregate property signal.

Parameters:
NUM_REQS, 4, number of FIFO channels observed
WIDTH, 8, data width per channel
DEPTH, 8, FIFO depth per channel (power of two not required)
OUT_LAT, 0, data_out latency after pop: 0 = same cycle, 1 = next cycle

Ports:
clk  input  1  single clock
rst  input  1  asynchronous reset, active-high
start  input  NUM_REQS  per-channel arm request, one-cycle pulse
push  input  NUM_REQS  per-channel push strobe into FIFOs
pop  input  NUM_REQS  per-channel grant/pop from arbiter, at most one hot
flat_data_in  input  NUM_REQS*WIDTH  packed push data, channel i at [(i+1)*WIDTH-1:i*WIDTH]
data_out  input  WIDTH  shared FIFO output data
done  output  NUM_REQS  channel i has checked its tagged packet (sticky)
chan_ok  output  NUM_REQS  0 once channel i sees mismatch or underflow (sticky)
prop_signal  output  1  &chan_ok

Behaviour:
- Reset (async, rst=1): all channels go to IDLE; occupancy=0, ahead=0, done=0, chan_ok=all 1s, prop_signal=1. Reset mid-tracking discards the tagged packet.
- Per-channel occupancy counter occ (CNTW=$clog2(DEPTH+1) bits) mirrors the FIFO:
  - A push is accepted iff occ<DEPTH or pop is high in the same cycle.
  - occ += accepted push − pop.
  - A pop with occ==0 is an underflow: clear chan_ok, hold occ at 0.
- Per-channel FSM, states IDLE, ARMED, TRACK, CHECK, DONE:
  - IDLE: start -> ARMED. A start in any other state is ignored.
  - ARMED: on an accepted push, capture data = flat_data_in slice and set ahead = occ − pop (entries in front of the tag). Go to TRACK. If the push is in the same cycle as start, it is captured (start|armed). Pushes while full are rejected and leave the FSM in ARMED.
  - TRACK: a pop with ahead>0 decrements ahead. A pop with ahead==0 is the tagged pop: if OUT_LAT=0, compare data_out against the captured data in that cycle and go to DONE; if OUT_LAT=1, go to CHECK.
  - CHECK (OUT_LAT=1 only): compare data_out in this cycle, then go to DONE.
  - DONE: terminal until reset. done=1 (registered, asserted the cycle after the compare). A mismatch clears chan_ok in the same registered update.
- Simultaneous push and pop on one channel: both counted. Capture ahead uses the post-pop count.
- Pop-hot rule: pop with more than one bit set clears chan_ok of every channel whose pop bit is set.
- All outputs are registered except prop_signal, which is a combinational AND of registered bits.

Decomposition:
- Package msb_pkg:
  - enum sb_state_t {IDLE, ARMED, TRACK, CHECK, DONE}
  - function cntw(depth) returning $clog2(depth+1)
- Sub-module msb_channel: one channel's occ, ahead, captured data and FSM. Generated NUM_REQS times.
- Top level: unpacks flat_data_in, runs the pop one-hot check, and forms the AND reduction.

Test Plan:
NUM_REQS=2, WIDTH=8, DEPTH=4, OUT_LAT=0 unless noted.
1. Basic order: push ch0 0x11, 0x22. Start+push ch0 0x33 in one cycle (ahead=2). Pop ch0 three times with data_out 0x11, 0x22, 0x33 -> done[0]=1 the cycle after the third pop; chan_ok=2'b11; prop_signal=1.
2. Mismatch: tag 0x5A on ch1 with empty FIFO, then pop ch1 with data_out=0x5B -> next cycle done[1]=1, chan_ok[1]=0, prop_signal=0.
3. Full rejection: fill ch0 to 4 entries, start ch0, push 0x77 while full with no pop -> state stays ARMED. Next cycle pop ch0 and push 0x88 together -> captured 0x88 with ahead=3; after 4 more pops the tag checks correctly.
4. Interleaved channels, OUT_LAT=1: tag ch0 0xA0 and ch1 0xB0, alternate pops ch1, ch0 with data_out one cycle late -> both done, prop_signal=1.
5. Faults: pop ch1 with occ=0 -> chan_ok[1]=0. Separately, pop=2'b11 -> both chan_ok cleared.
6. Async reset asserted mid-TRACK, between clock edges -> done=0, chan_ok=11 and prop_signal=1 immediately; start on the first cycle after release re-arms.

Source files
------------

// File: rtl/msb_pkg.sv
// rtl/msb_pkg.sv - shared types and helpers for the multi-channel scoreboard
package msb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        TRACK,
        CHECK,
        DONE
    } sb_state_t;

    function automatic int cntw(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/multi_channel_scoreboard_if.sv
// rtl/multi_channel_scoreboard_if.sv - observed FIFO-array signals and scoreboard verdicts
interface multi_channel_scoreboard_if #(
    parameter int NUM_REQS = 4,
    parameter int WIDTH    = 8
);
    logic [NUM_REQS-1:0]       start;
    logic [NUM_REQS-1:0]       push;
    logic [NUM_REQS-1:0]       pop;
    logic [NUM_REQS*WIDTH-1:0] flat_data_in;
    logic [WIDTH-1:0]          data_out;
    logic [NUM_REQS-1:0]       done;
    logic [NUM_REQS-1:0]       chan_ok;
    logic                      prop_signal;

    modport master (
        output start, push, pop, flat_data_in, data_out,
        input  done, chan_ok, prop_signal
    );

    modport slave (
        input  start, push, pop, flat_data_in, data_out,
        output done, chan_ok, prop_signal
    );
endinterface

// File: rtl/msb_channel.sv
// rtl/msb_channel.sv - one channel: FIFO occupancy mirror, tag capture and in-order check
module msb_channel
    import msb_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 8,
    parameter int OUT_LAT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             pop_multi_i,
    input  logic [WIDTH-1:0] data_in_i,
    input  logic [WIDTH-1:0] data_out_i,
    output logic             done_o,
    output logic             ok_o
);
    localparam int               CNTW    = cntw(DEPTH);
    localparam logic [CNTW-1:0]  DEPTH_C = CNTW'(DEPTH);
    localparam logic [CNTW-1:0]  ONE_C   = CNTW'(1);

    sb_state_t        state_q;
    logic [CNTW-1:0]  occ_q, occ_d, occ_post_pop, ahead_q;
    logic [WIDTH-1:0] tag_q;
    logic             done_q, ok_q;
    logic             push_acc, underflow, pop_eff, armed;

    always_comb begin
        push_acc     = push_i && ((occ_q < DEPTH_C) || pop_i);
        underflow    = pop_i && (occ_q == '0);
        pop_eff      = pop_i && !underflow;
        occ_post_pop = occ_q - CNTW'(pop_eff);
        occ_d        = occ_post_pop + CNTW'(push_acc);
        // A start pulse arms the channel in the same cycle so a coincident push is the tag
        armed        = (state_q == ARMED) || ((state_q == IDLE) && start_i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            occ_q   <= '0;
            ahead_q <= '0;
            tag_q   <= '0;
            done_q  <= 1'b0;
            ok_q    <= 1'b1;
        end else begin
            occ_q <= occ_d;
            if (underflow || (pop_i && pop_multi_i))
                ok_q <= 1'b0;
            if (armed && push_acc) begin
                tag_q   <= data_in_i;
                ahead_q <= occ_post_pop;
                state_q <= TRACK;
            end else if (armed) begin
                state_q <= ARMED;
            end else begin
                case (state_q)
                    TRACK: begin
                        if (pop_i) begin
                            if (ahead_q != '0) begin
                                ahead_q <= ahead_q - ONE_C;
                            end else if (OUT_LAT == 0) begin
                                done_q  <= 1'b1;
                                state_q <= DONE;
                                if (data_out_i != tag_q)
                                    ok_q <= 1'b0;
                            end else begin
                                state_q <= CHECK;
                            end
                        end
                    end
                    CHECK: begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                        if (data_out_i != tag_q)
                            ok_q <= 1'b0;
                    end
                    IDLE, DONE: ;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign done_o = done_q;
    assign ok_o   = ok_q;

endmodule

// File: rtl/multi_channel_scoreboard.sv
// rtl/multi_channel_scoreboard.sv - per-channel FIFO-order checkers with pop one-hot guard
module multi_channel_scoreboard
    import msb_pkg::*;
#(
    parameter int NUM_REQS = 4,
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int OUT_LAT  = 0
) (
    input logic                         clk,
    input logic                         rst,
    multi_channel_scoreboard_if.slave   sb
);
    logic [NUM_REQS-1:0] done_w;
    logic [NUM_REQS-1:0] ok_w;
    logic                pop_multi;

    // Clearing the lowest set bit leaves something only when two or more grants are high
    assign pop_multi = (sb.pop & (sb.pop - {{(NUM_REQS-1){1'b0}}, 1'b1})) != '0;

    for (genvar i = 0; i < NUM_REQS; i++) begin : g_chan
        msb_channel #(
            .WIDTH   (WIDTH),
            .DEPTH   (DEPTH),
            .OUT_LAT (OUT_LAT)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .start_i     (sb.start[i]),
            .push_i      (sb.push[i]),
            .pop_i       (sb.pop[i]),
            .pop_multi_i (pop_multi),
            .data_in_i   (sb.flat_data_in[i*WIDTH +: WIDTH]),
            .data_out_i  (sb.data_out),
            .done_o      (done_w[i]),
            .ok_o        (ok_w[i])
        );
    end

    assign sb.done        = done_w;
    assign sb.chan_ok     = ok_w;
    assign sb.prop_signal = &ok_w;

endmodule

// File: tb/tb_multi_channel_scoreboard.sv
// tb/tb_multi_channel_scoreboard.sv - directed checks of the multi-channel scoreboard
module tb_multi_channel_scoreboard;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    multi_channel_scoreboard_if #(.NUM_REQS(2), .WIDTH(8)) ba ();
    multi_channel_scoreboard_if #(.NUM_REQS(2), .WIDTH(8)) bb ();

    multi_channel_scoreboard #(.NUM_REQS(2), .WIDTH(8), .DEPTH(4), .OUT_LAT(0)) dut_a (
        .clk (clk),
        .rst (rst),
        .sb  (ba)
    );

    multi_channel_scoreboard #(.NUM_REQS(2), .WIDTH(8), .DEPTH(4), .OUT_LAT(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .sb  (bb)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_all();
        ba.start = '0; ba.push = '0; ba.pop = '0; ba.flat_data_in = '0; ba.data_out = '0;
        bb.start = '0; bb.push = '0; bb.pop = '0; bb.flat_data_in = '0; bb.data_out = '0;
    endtask

    task automatic step_a(input logic [1:0] st, input logic [1:0] ps, input logic [1:0] pp,
                          input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] dout);
        ba.start = st; ba.push = ps; ba.pop = pp;
        ba.flat_data_in = {d1, d0}; ba.data_out = dout;
        @(posedge clk);
        #1;
        idle_all();
    endtask

    task automatic step_b(input logic [1:0] st, input logic [1:0] ps, input logic [1:0] pp,
                          input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] dout);
        bb.start = st; bb.push = ps; bb.pop = pp;
        bb.flat_data_in = {d1, d0}; bb.data_out = dout;
        @(posedge clk);
        #1;
        idle_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        idle_all();
        @(posedge clk);
        #1;
        check("reset_done",    {6'd0, ba.done},    8'h00);
        check("reset_chan_ok", {6'd0, ba.chan_ok}, 8'h03);
        check("reset_prop",    {7'd0, ba.prop_signal}, 8'h01);
        rst = 1'b0;

        // Basic order: tag 0x33 behind two entries
        step_a(2'b00, 2'b01, 2'b00, 8'h11, 8'h00, 8'h00);
        step_a(2'b00, 2'b01, 2'b00, 8'h22, 8'h00, 8'h00);
        step_a(2'b01, 2'b01, 2'b00, 8'h33, 8'h00, 8'h00);
        step_a(2'b00, 2'b00, 2'b01, 8'h00, 8'h00, 8'h11);
        step_a(2'b00, 2'b00, 2'b01, 8'h00, 8'h00, 8'h22);
        check("order_not_done_early", {6'd0, ba.done}, 8'h00);
        step_a(2'b00, 2'b00, 2'b01, 8'h00, 8'h00, 8'h33);
        check("order_done",    {6'd0, ba.done},    8'h01);
        check("order_chan_ok", {6'd0, ba.chan_ok}, 8'h03);
        check("order_prop",    {7'd0, ba.prop_signal}, 8'h01);

        // Mismatch on ch1
        do_reset();
        step_a(2'b10, 2'b10, 2'b00, 8'h00, 8'h5A, 8'h00);
        step_a(2'b00, 2'b00, 2'b10, 8'h00, 8'h00, 8'h5B);
        check("mismatch_done",    {6'd0, ba.done},    8'h02);
        check("mismatch_chan_ok", {6'd0, ba.chan_ok}, 8'h01);
        check("mismatch_prop",    {7'd0, ba.prop_signal}, 8'h00);

        // Full rejection: push 0x77 while full must not be captured
        do_reset();
        for (int i = 1; i <= 4; i++)
            step_a(2'b00, 2'b01, 2'b00, 8'(i), 8'h00, 8'h00);
        step_a(2'b01, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00);
        step_a(2'b00, 2'b01, 2'b00, 8'h77, 8'h00, 8'h00);
        step_a(2'b00, 2'b01, 2'b01, 8'h88, 8'h00, 8'h01);
        step_a(2'b00, 2'b00, 2'b01, 8'h00, 8'h00, 8'h02);
        step_a(2'b00, 2'b00, 2'b01, 8'h00, 8'h00, 8'h03);
        step_a(2'b00, 2'b00, 2'b01, 8'h00, 8'h00, 8'h04);
        check("full_not_done_early", {6'd0, ba.done},    8'h00);
        check("full_chan_ok_mid",    {6'd0, ba.chan_ok}, 8'h03);
        step_a(2'b00, 2'b00, 2'b01, 8'h00, 8'h00, 8'h88);
        check("full_done",    {6'd0, ba.done},    8'h01);
        check("full_chan_ok", {6'd0, ba.chan_ok}, 8'h03);

        // Interleaved channels with one-cycle output latency
        do_reset();
        step_b(2'b11, 2'b11, 2'b00, 8'hA0, 8'hB0, 8'h00);
        step_b(2'b00, 2'b00, 2'b10, 8'h00, 8'h00, 8'h00);
        check("lat1_not_done_early", {6'd0, bb.done}, 8'h00);
        step_b(2'b00, 2'b00, 2'b01, 8'h00, 8'h00, 8'hB0);
        check("lat1_ch1_done", {6'd0, bb.done}, 8'h02);
        step_b(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'hA0);
        check("lat1_done",    {6'd0, bb.done},    8'h03);
        check("lat1_chan_ok", {6'd0, bb.chan_ok}, 8'h03);
        check("lat1_prop",    {7'd0, bb.prop_signal}, 8'h01);

        // Underflow on ch1
        do_reset();
        step_a(2'b00, 2'b00, 2'b10, 8'h00, 8'h00, 8'h00);
        check("underflow_chan_ok", {6'd0, ba.chan_ok}, 8'h01);
        check("underflow_prop",    {7'd0, ba.prop_signal}, 8'h00);

        // Two grants at once
        do_reset();
        step_a(2'b00, 2'b11, 2'b00, 8'h01, 8'h02, 8'h00);
        step_a(2'b00, 2'b00, 2'b11, 8'h00, 8'h00, 8'h01);
        check("multi_pop_chan_ok", {6'd0, ba.chan_ok}, 8'h00);

        // Async reset mid-TRACK with ch1 already done and failed
        do_reset();
        step_a(2'b10, 2'b10, 2'b00, 8'h00, 8'h44, 8'h00);
        step_a(2'b00, 2'b00, 2'b10, 8'h00, 8'h00, 8'h45);
        step_a(2'b01, 2'b01, 2'b00, 8'hAA, 8'h00, 8'h00);
        check("pre_reset_done",    {6'd0, ba.done},    8'h02);
        check("pre_reset_chan_ok", {6'd0, ba.chan_ok}, 8'h01);
        #3 rst = 1'b1;
        #1;
        check("async_reset_done",    {6'd0, ba.done},    8'h00);
        check("async_reset_chan_ok", {6'd0, ba.chan_ok}, 8'h03);
        check("async_reset_prop",    {7'd0, ba.prop_signal}, 8'h01);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step_a(2'b01, 2'b01, 2'b00, 8'h3C, 8'h00, 8'h00);
        step_a(2'b00, 2'b00, 2'b01, 8'h00, 8'h00, 8'h3C);
        check("rearm_done",    {6'd0, ba.done},    8'h01);
        check("rearm_chan_ok", {6'd0, ba.chan_ok}, 8'h03);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
